headgen_pipe_s3: RTL and testbench

Final stage of the encapsulation header-generation pipeline. It sits directly downstream of the stage-2 register set, which produces the frame word-count, the partial checksum sum and the IP identification.
- Computes total length and the final one's-complement IPv4 header checksum.
- Serialises the 20-byte IPv4 outer header as ten 16-bit words over a valid/ready stream into the frame assembler.
- Drives `in_ready` back to the upstream stages; upstream stages use it as their `enableout`.

---
 rtl/headgen_pipe_s3_pkg.sv | 18 +
 rtl/headgen_pipe_s3_fold.sv | 15 +
 rtl/headgen_pipe_s3.sv | 173 +++++++++++++++++
 tb/tb_headgen_pipe_s3.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/headgen_pipe_s3_pkg.sv
// Shared types and constants for the stage-3 IPv4 outer-header generator.
// Pulled in by headgen_pipe_s3 and its checksum fold helper.
package headgen_pipe_s3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int unsigned HDR_WORDS      = 10;
  localparam logic [3:0]  LAST_WORD_IDX  = 4'd9;

  localparam logic [15:0] HDR_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] HDR_FLAGS_FRAG  = 16'h4000;
  localparam logic [15:0] IPV4_HDR_BYTES  = 16'd20;

endpackage

// File: rtl/headgen_pipe_s3_fold.sv
// One's-complement end-around-carry fold, 17-bit sum to 16 bits.
// Folds twice so a carry produced by the first fold is also wrapped back in.
module ones_comp_fold16 (
  input  logic [16:0] sum_i,
  output logic [15:0] fold_o
);

  logic [16:0] first_fold;

  always_comb begin
    first_fold = {1'b0, sum_i[15:0]} + {16'b0, sum_i[16]};
    fold_o     = first_fold[15:0] + {15'b0, first_fold[16]};
  end

endmodule

// File: rtl/headgen_pipe_s3.sv
// Stage-3 header generator: final IPv4 checksum and 10-word header serialiser.
// Optional build macro HEADGEN_S3_STATS_EN adds hdr_count / stall_cycles outputs.
//
// state   | meaning
// IDLE    | in_ready high, waiting to capture a triple
// CALC    | one cycle, folds the checksum
// SEND    | streams header words 0..9 under hdr_ready
module headgen_pipe_s3
  import headgen_pipe_s3_pkg::*;
#(
  parameter logic [7:0]  TTL       = 8'd64,
  parameter logic [7:0]  PROTO     = 8'd47,
  parameter int unsigned LEN_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_0,
  input  logic [15:0] in_1,
  input  logic [15:0] in_2,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] hdr_data,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        hdr_last
`ifdef HEADGEN_S3_STATS_EN
  ,
  output logic [15:0] hdr_count,
  output logic [15:0] stall_cycles
`endif
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [15:0] psum_q, psum_d;
  logic [15:0] id_q, id_d;
  logic [15:0] cksum_q, cksum_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;

  logic [16:0] sum17;
  logic [15:0] folded;
  logic        word_hs;

  assign sum17 = {1'b0, psum_q} + {1'b0, tot_len_q};

  ones_comp_fold16 u_fold (
    .sum_i  (sum17),
    .fold_o (folded)
  );

  // in_ready is held low while rst is asserted so nothing is offered as accepted
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign hdr_valid = (state_q == ST_SEND);
  assign hdr_last  = (state_q == ST_SEND) && (cnt_q == LAST_WORD_IDX);
  assign word_hs   = hdr_valid && hdr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tot_len_d = tot_len_q;
    psum_d    = psum_q;
    id_d      = id_q;
    cksum_d   = cksum_q;
    src_d     = src_q;
    dst_d     = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          tot_len_d = ({7'b0, in_0} << LEN_SHIFT) + IPV4_HDR_BYTES;
          psum_d    = in_1;
          id_d      = in_2;
          src_d     = src_ip;
          dst_d     = dst_ip;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        cksum_d = ~folded;
        cnt_d   = 4'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (word_hs) begin
          if (cnt_q == LAST_WORD_IDX) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    hdr_data = 16'h0000;
    if (state_q == ST_SEND) begin
      case (cnt_q)
        4'd0:    hdr_data = HDR_VER_IHL_TOS;
        4'd1:    hdr_data = tot_len_q;
        4'd2:    hdr_data = id_q;
        4'd3:    hdr_data = HDR_FLAGS_FRAG;
        4'd4:    hdr_data = {TTL, PROTO};
        4'd5:    hdr_data = cksum_q;
        4'd6:    hdr_data = src_q[31:16];
        4'd7:    hdr_data = src_q[15:0];
        4'd8:    hdr_data = dst_q[31:16];
        4'd9:    hdr_data = dst_q[15:0];
        default: hdr_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      tot_len_q <= 16'h0000;
      psum_q    <= 16'h0000;
      id_q      <= 16'h0000;
      cksum_q   <= 16'h0000;
      src_q     <= 32'h0000_0000;
      dst_q     <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tot_len_q <= tot_len_d;
      psum_q    <= psum_d;
      id_q      <= id_d;
      cksum_q   <= cksum_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
    end
  end

`ifdef HEADGEN_S3_STATS_EN
  logic [15:0] hdr_count_q, hdr_count_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    hdr_count_d = hdr_count_q;
    stall_d     = stall_q;
    if (word_hs && (cnt_q == LAST_WORD_IDX)) begin
      hdr_count_d = hdr_count_q + 16'd1;
    end
    if (hdr_valid && !hdr_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_count_q <= 16'h0000;
      stall_q     <= 16'h0000;
    end else begin
      hdr_count_q <= hdr_count_d;
      stall_q     <= stall_d;
    end
  end

  assign hdr_count    = hdr_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_headgen_pipe_s3.sv
// Directed bench for headgen_pipe_s3; inputs change and outputs are sampled on negedge.
module tb_headgen_pipe_s3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_0;
  logic [15:0] in_1;
  logic [15:0] in_2;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] hdr_data;
  logic        hdr_valid;
  logic        hdr_ready;
  logic        hdr_last;
`ifdef HEADGEN_S3_STATS_EN
  logic [15:0] hdr_count;
  logic [15:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  headgen_pipe_s3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_0      (in_0),
    .in_1      (in_1),
    .in_2      (in_2),
    .src_ip    (src_ip),
    .dst_ip    (dst_ip),
    .hdr_data  (hdr_data),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .hdr_last  (hdr_last)
`ifdef HEADGEN_S3_STATS_EN
    ,
    .hdr_count    (hdr_count),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full header with hdr_ready high except a 3-cycle stall at word stall_at (-1 = none).
  task automatic send_hdr(input string tag, input logic [8:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] exp_len, input logic [15:0] exp_ck,
                          input int stall_at);
    logic [15:0] exp_w [10];
    exp_w[0] = 16'h4500; exp_w[1] = exp_len;     exp_w[2] = a2;         exp_w[3] = 16'h4000;
    exp_w[4] = 16'h402F; exp_w[5] = exp_ck;      exp_w[6] = s[31:16];   exp_w[7] = s[15:0];
    exp_w[8] = d[31:16]; exp_w[9] = d[15:0];

    @(negedge clk);
    check({tag, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_0 = a0; in_1 = a1; in_2 = a2; src_ip = s; dst_ip = d;
    @(negedge clk);
    in_valid = 1'b0;
    src_ip = ~s; dst_ip = ~d;
    check({tag, " calc valid"}, {31'b0, hdr_valid}, 32'd0);
    check({tag, " calc in_ready"}, {31'b0, in_ready}, 32'd0);
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (w == stall_at) begin
        hdr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("%s hold w%0d", tag, w), {16'b0, hdr_data}, {16'b0, exp_w[w]});
          check($sformatf("%s hold valid", tag), {31'b0, hdr_valid}, 32'd1);
          check($sformatf("%s hold in_ready", tag), {31'b0, in_ready}, 32'd0);
          @(negedge clk);
        end
        hdr_ready = 1'b1;
      end
      check($sformatf("%s valid w%0d", tag, w), {31'b0, hdr_valid}, 32'd1);
      check($sformatf("%s data w%0d", tag, w), {16'b0, hdr_data}, {16'b0, exp_w[w]});
      check($sformatf("%s last w%0d", tag, w), {31'b0, hdr_last}, {31'b0, (w == 9)});
    end
    @(negedge clk);
    check({tag, " end valid"}, {31'b0, hdr_valid}, 32'd0);
    check({tag, " end last"}, {31'b0, hdr_last}, 32'd0);
    check({tag, " end in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int acc_n, last_n;
    int acc_c [2];
    int last_c [2];

    rst = 1'b1; in_valid = 1'b0; hdr_ready = 1'b1;
    in_0 = '0; in_1 = '0; in_2 = '0; src_ip = '0; dst_ip = '0;
    #12;
    check("rst hdr_valid", {31'b0, hdr_valid}, 32'd0);
    check("rst hdr_last", {31'b0, hdr_last}, 32'd0);
    check("rst hdr_data", {16'b0, hdr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    send_hdr("basic", 9'd10, 16'hB861, 16'h1234, 32'h0A000001, 32'h0A000002,
             16'h0064, 16'h473A, -1);
    send_hdr("carry", 9'd10, 16'hFFF0, 16'h0001, 32'hC0A80101, 32'h08080808,
             16'h0064, 16'hFFAA, -1);
    send_hdr("maxlen", 9'h1FF, 16'h0000, 16'hBEEF, 32'h01020304, 32'h05060708,
             16'h100C, 16'hEFF3, -1);
    send_hdr("bp", 9'd10, 16'hB861, 16'h1234, 32'h0A000001, 32'h0A000002,
             16'h0064, 16'h473A, 4);

    // back-to-back with in_valid held high
    acc_n = 0; last_n = 0;
    acc_c[0] = -100; acc_c[1] = -100; last_c[0] = -100; last_c[1] = -100;
    @(negedge clk);
    in_valid = 1'b1; in_0 = 9'd10; in_1 = 16'hB861; in_2 = 16'h1234;
    src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
    for (int c = 0; c < 30; c++) begin
      if (in_valid && in_ready && acc_n < 2) begin acc_c[acc_n] = c; acc_n++; end
      if (hdr_valid && hdr_ready && hdr_last && last_n < 2) begin last_c[last_n] = c; last_n++; end
      if (c == 13) check("b2b 2nd tot_len pending", {31'b0, in_ready}, 32'd0);
      if (c == 15) check("b2b 2nd w1 tot_len", {16'b0, hdr_data}, 32'h00B4);
      @(negedge clk);
      if (acc_n == 1) begin in_0 = 9'd20; in_2 = 16'h5678; end
      if (acc_n == 2) in_valid = 1'b0;
    end
    check("b2b accepts", acc_n, 32'd2);
    check("b2b lasts", last_n, 32'd2);
    check("b2b first last at T+11", last_c[0] - acc_c[0], 32'd11);
    check("b2b 2nd accept after last", acc_c[1] - last_c[0], 32'd1);
    check("b2b period", acc_c[1] - acc_c[0], 32'd12);
    check("b2b last period", last_c[1] - last_c[0], 32'd12);

    // reset asserted asynchronously while word 3 is on the bus
    @(negedge clk);
    in_valid = 1'b1; in_0 = 9'd10; in_1 = 16'hB861; in_2 = 16'h1234;
    src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid w3 data", {16'b0, hdr_data}, 32'h4000);
    #2 rst = 1'b1;
    #1;
    check("rst mid valid", {31'b0, hdr_valid}, 32'd0);
    check("rst mid last", {31'b0, hdr_last}, 32'd0);
    check("rst mid data", {16'b0, hdr_data}, 32'd0);
`ifdef HEADGEN_S3_STATS_EN
    check("rst hdr_count", {16'b0, hdr_count}, 32'd0);
    check("rst stall_cycles", {16'b0, stall_cycles}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel in_ready", {31'b0, in_ready}, 32'd1);
    check("rel valid", {31'b0, hdr_valid}, 32'd0);
    send_hdr("after-rst", 9'd10, 16'hB861, 16'h1234, 32'h0A000001, 32'h0A000002,
             16'h0064, 16'h473A, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
